// File: rtl/framebuffer_db.sv
// Double-buffered framebuffer: draw into one bank, scan the other, swap on frame start.
// Ports: clk/rst, draw port (we,x,y,color,wr_ready), clear_req, swap_req, frame_start,
//        scanout (scan_en,scan_x,scan_y -> r,g,b), status (swapped, busy, oob_err).
module framebuffer_db #(
  parameter int CORDW = 10,
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int COLORW = 3,
  parameter logic [COLORW-1:0] CLEAR_COLOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [CORDW-1:0]    x,
  input  logic [CORDW-1:0]    y,
  input  logic [COLORW-1:0]   color,
  output logic                wr_ready,
  input  logic                clear_req,
  input  logic                swap_req,
  input  logic                frame_start,
  input  logic                scan_en,
  input  logic [CORDW-1:0]    scan_x,
  input  logic [CORDW-1:0]    scan_y,
  output logic [COLORW/3-1:0] r,
  output logic [COLORW/3-1:0] g,
  output logic [COLORW/3-1:0] b,
  output logic                swapped,
  output logic                busy,
  output logic                oob_err
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int AW = $clog2(N);
  localparam int CW = COLORW / 3;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SWAP_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [COLORW-1:0] r_mem [2][N];
  logic [COLORW-1:0] r_pix;
  logic [AW-1:0]     r_cnt;
  logic              r_disp_sel;
  logic              r_pend;
  logic              r_oob;
  logic              r_swapped;

  logic          w_draw_sel;
  logic          w_wr_in;
  logic          w_scan_in;
  logic          w_wr;
  logic          w_oob;
  logic          w_swap;
  logic          w_clr_last;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_raddr;

  assign w_draw_sel = ~r_disp_sel;
  assign busy       = (r_state != IDLE);
  assign wr_ready   = ~busy;

  assign w_wr_in   = (32'(x) < WIDTH) &&
                     (32'(y) < HEIGHT);
  assign w_scan_in = (32'(scan_x) < WIDTH) &&
                     (32'(scan_y) < HEIGHT);

  assign w_waddr = AW'(32'(y) * WIDTH + 32'(x));
  assign w_raddr = AW'(32'(scan_y) * WIDTH
                   + 32'(scan_x));

  assign w_wr  = we & wr_ready & w_wr_in;
  assign w_oob = we & wr_ready & ~w_wr_in;

  assign w_clr_last = (r_cnt == LAST);
  assign w_swap = (r_state == SWAP_WAIT)
                  & frame_start;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (clear_req)
          w_next = CLEAR;
        else if (swap_req)
          w_next = SWAP_WAIT;
      end
      CLEAR: begin
        // a swap_req on the final clear cycle still counts
        if (w_clr_last)
          w_next = (r_pend | swap_req) ?
                   SWAP_WAIT : IDLE;
      end
      SWAP_WAIT: begin
        if (frame_start)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_disp_sel <= 1'b0;
      r_pend     <= 1'b0;
      r_cnt      <= '0;
      r_oob      <= 1'b0;
      r_swapped  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_swapped <= w_swap;
      if (w_swap)
        r_disp_sel <= ~r_disp_sel;
      if (w_oob)
        r_oob <= 1'b1;
      if (r_state == CLEAR) begin
        r_cnt <= w_clr_last ? '0 : r_cnt + 1'b1;
        if (w_clr_last)
          r_pend <= 1'b0;
        else if (swap_req)
          r_pend <= 1'b1;
      end else begin
        r_cnt  <= '0;
        r_pend <= 1'b0;
      end
    end
  end

  // pixel storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (r_state == CLEAR)
      r_mem[w_draw_sel][r_cnt] <= CLEAR_COLOR;
    else if (w_wr)
      r_mem[w_draw_sel][w_waddr] <= color;
  end

  // read uses the pre-edge r_disp_sel, so a read on
  // the swap edge still returns the old bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pix <= '0;
    else if (scan_en && w_scan_in)
      r_pix <= r_mem[r_disp_sel][w_raddr];
    else
      r_pix <= '0;
  end

  assign r       = r_pix[COLORW-1 -: CW];
  assign g       = r_pix[2*CW-1 -: CW];
  assign b       = r_pix[CW-1:0];
  assign swapped = r_swapped;
  assign oob_err = r_oob;

endmodule

// File: doc/framebuffer_db.md
FRAMEBUFFER_DB -- requirements
Module: framebuffer_db

Interface
REQ-001 SHALL have parameter CORDW, default 10: coordinate width in bits.
REQ-002 SHALL have parameter WIDTH, default 640: pixels per line.
REQ-003 SHALL have parameter HEIGHT, default 480: lines per frame.
REQ-004 SHALL have parameter COLORW, default 3: bits per pixel, split evenly into R, G, B (COLORW multiple of 3).
REQ-005 SHALL have parameter CLEAR_COLOR, default 0: COLORW-bit value written by a clear.
REQ-006 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- we  in  1  draw-port write enable.
- x  in  CORDW  draw x.
- y  in  CORDW  draw y.
- color  in  COLORW  draw pixel value.
- wr_ready  out  1  draw port accepts writes.
- clear_req  in  1  single-cycle pulse; start clear of the draw bank.
- swap_req  in  1  single-cycle pulse; request bank swap.
- frame_start  in  1  single-cycle pulse at start of the display frame.
- scan_en  in  1  scanout read enable.
- scan_x  in  CORDW  scanout x.
- scan_y  in  CORDW  scanout y.
- r, g, b  out  COLORW/3 each  scanout pixel.
- swapped  out  1  one-cycle pulse when a swap takes effect.
- busy  out  1  clear in progress or swap pending.
- oob_err  out  1  sticky flag: out-of-range write attempted.

Function
REQ-007 SHALL hold two banks of WIDTH*HEIGHT pixels; address = y*WIDTH + x, width $clog2(WIDTH*HEIGHT).
REQ-008 SHALL treat one bank as the draw bank (written) and the other as the display bank (scanned); draw_sel is the inverse of disp_sel.
REQ-009 SHALL write color to the draw bank at (x,y) on the clock edge where we=1, wr_ready=1, x<WIDTH and y<HEIGHT.
REQ-010 SHALL drop writes with x>=WIDTH or y>=HEIGHT and set oob_err=1 until reset.
REQ-011 SHALL ignore we while wr_ready=0, without setting oob_err.
REQ-012 SHALL present display-bank data on {r,g,b} one cycle after scan_en=1 with in-range (scan_x,scan_y); r = color[COLORW-1 -: COLORW/3], b = LSB third.
REQ-013 SHALL drive {r,g,b}=0 one cycle after scan_en=0 or an out-of-range scan address.
REQ-014 SHALL implement FSM states IDLE, CLEAR, SWAP_WAIT.
REQ-015 IDLE: clear_req -> CLEAR; else swap_req -> SWAP_WAIT; clear_req has priority if both assert.
REQ-016 CLEAR SHALL write CLEAR_COLOR to draw-bank addresses 0..WIDTH*HEIGHT-1, one per cycle, with wr_ready=0, taking exactly WIDTH*HEIGHT cycles.
REQ-017 CLEAR SHALL latch swap_req as pending and, after the last address, go to SWAP_WAIT if pending, else IDLE.
REQ-018 clear_req in CLEAR or SWAP_WAIT SHALL be ignored.
REQ-019 SWAP_WAIT: wr_ready=0; on frame_start, toggle disp_sel, pulse swapped for one cycle, return to IDLE.
REQ-020 swap_req in SWAP_WAIT SHALL be ignored (no double swap).
REQ-021 frame_start in IDLE or CLEAR SHALL have no effect.
REQ-022 A scan read on the same cycle as the swap edge SHALL return old display-bank data; reads from the next cycle on SHALL use the new bank.
REQ-023 busy SHALL be 1 in CLEAR and SWAP_WAIT, 0 in IDLE; wr_ready = !busy.
REQ-024 Display-bank contents SHALL never be modified by writes or clears.

Reset
REQ-025 rst SHALL force IDLE, disp_sel=0, swap pending=0, clear counter=0, r=g=b=0, swapped=0, busy=0, oob_err=0, wr_ready=1.
REQ-026 Memory contents SHALL NOT be reset; rst during CLEAR SHALL abort the clear, leaving partially cleared contents.

Verification (WIDTH=HEIGHT=10, COLORW=3, CLEAR_COLOR=0)
REQ-027 Write (3,3)=3'b011, swap_req, frame_start, scan (3,3) -> swapped pulses once; next cycle r=0,g=1,b=1.
REQ-028 Write (3,3)=3'b110 without swap, scan (3,3) -> rgb equals prior display value; draw-bank write invisible.
REQ-029 Write (10,2)=3'b111 -> oob_err=1 and stays 1; scan of (10,2) -> rgb=0.
REQ-030 clear_req -> wr_ready=0 for exactly 100 cycles; writes during clear dropped; after swap, all 100 pixels read 0.
REQ-031 swap_req during CLEAR, frame_start at clear cycle 50 -> no swap; swap occurs at first frame_start after clear completes.
REQ-032 Assert rst at clear cycle 40 -> all outputs at reset values, state IDLE, wr_ready=1 next cycle.
